// File: rtl/snake_step_ctrl.sv
// Game-step controller: button edges -> direction, step tick, snake length and game state.
// Optional SNAKE_SPEEDUP_EN: each apple shortens the tick period by one clk (floor 2).
module snake_step_ctrl #(
  parameter int TICK_DIV = 8,
  parameter int INIT_LEN = 3,
  parameter int MAX_LEN  = 64,
  parameter int LEN_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             head_at_apple,
  input  logic             head_hit_body,
  output logic             tick,
  output logic [1:0]       direction,
  output logic [LEN_W-1:0] hold_time,
  output logic             eat_apple,
  output logic             game_over,
  output logic             running
);

  // state | meaning
  // IDLE  | waiting for first button edge, no ticks
  // RUN   | game stepping, tick every period clks
  // OVER  | collision seen, waiting for a button edge to restart
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

  localparam int CNT_W = $clog2(TICK_DIV + 1);

  state_t           state, state_nxt;
  logic [3:0]       btn_now, btn_hist, btn_edge;
  logic             any_edge;
  logic [1:0]       win_dir;
  logic [1:0]       pend;
  logic             pend_vld;
  logic [CNT_W-1:0] cnt, cnt_last;
  logic             tick_cyc;

  assign btn_now  = {btn_up, btn_down, btn_left, btn_right};
  assign btn_edge = btn_now & ~btn_hist;
  assign any_edge = |btn_edge;

  always_comb begin
    win_dir = 2'b00;
    if (btn_edge[3])      win_dir = 2'b11;
    else if (btn_edge[2]) win_dir = 2'b01;
    else if (btn_edge[1]) win_dir = 2'b10;
    else                  win_dir = 2'b00;
  end

`ifdef SNAKE_SPEEDUP_EN
  logic [CNT_W-1:0] period;
  assign cnt_last = period - CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period <= CNT_W'(TICK_DIV);
    end else if (state == S_OVER && any_edge) begin
      period <= CNT_W'(TICK_DIV);
    end else if (tick_cyc && !head_hit_body && head_at_apple && period > CNT_W'(2)) begin
      period <= period - CNT_W'(1);
    end
  end
`else
  assign cnt_last = CNT_W'(TICK_DIV - 1);
`endif

  assign tick_cyc  = (state == S_RUN) && (cnt == cnt_last);
  assign tick      = tick_cyc;
  assign running   = (state == S_RUN);
  assign game_over = (state == S_OVER);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_edge) state_nxt = S_RUN;
      S_RUN:   if (tick_cyc && head_hit_body) state_nxt = S_OVER;
      S_OVER:  if (any_edge) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_hist  <= 4'b0000;
      cnt       <= '0;
      pend      <= 2'b00;
      pend_vld  <= 1'b0;
      direction <= 2'b00;
      hold_time <= LEN_W'(INIT_LEN);
      eat_apple <= 1'b0;
    end else begin
      btn_hist <= btn_now;
      cnt      <= (state == S_RUN && !tick_cyc) ? cnt + CNT_W'(1) : '0;
      case (state)
        S_IDLE: begin
          if (any_edge) begin
            pend     <= win_dir;
            pend_vld <= 1'b1;
          end
        end
        S_RUN: begin
          if (tick_cyc) begin
            pend_vld <= 1'b0;
            if (head_hit_body) begin
              eat_apple <= 1'b0;
            end else begin
              eat_apple <= head_at_apple;
              if (head_at_apple && hold_time < LEN_W'(MAX_LEN))
                hold_time <= hold_time + LEN_W'(1);
              if (pend_vld && pend != (direction ^ 2'b10))
                direction <= pend;
            end
          end
          // an edge in the tick cycle itself is queued for the following tick
          if (any_edge) begin
            pend     <= win_dir;
            pend_vld <= 1'b1;
          end
        end
        S_OVER: begin
          eat_apple <= 1'b0;
          if (any_edge) begin
            hold_time <= LEN_W'(INIT_LEN);
            direction <= 2'b00;
            pend_vld  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed self-checking bench for snake_step_ctrl (default build or SNAKE_SPEEDUP_EN).
module tb_snake_step_ctrl;

`ifdef SNAKE_SPEEDUP_EN
  localparam int TB_MAX = 64;
`else
  localparam int TB_MAX = 4;
`endif

  logic       clk, reset;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       head_at_apple, head_hit_body;
  logic       tick, eat_apple, game_over, running;
  logic [1:0] direction;
  logic [7:0] hold_time;

  int vectors = 0;
  int errors  = 0;
  int exp_per = 8;
  int exp_hold;
  int n, tcount;

  snake_step_ctrl #(.TICK_DIV(8), .INIT_LEN(3), .MAX_LEN(TB_MAX), .LEN_W(8)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .head_at_apple(head_at_apple), .head_hit_body(head_hit_body),
    .tick(tick), .direction(direction), .hold_time(hold_time),
    .eat_apple(eat_apple), .game_over(game_over), .running(running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(output int cycles);
    cycles = 0;
    while (tick !== 1'b1 && cycles < 200) begin
      step();
      cycles++;
    end
    chk("tick_seen", {31'd0, tick}, 1);
  endtask

  task automatic apple_eaten();
`ifdef SNAKE_SPEEDUP_EN
    if (exp_per > 2) exp_per--;
`endif
    exp_hold = (exp_hold + 1 > TB_MAX) ? TB_MAX : exp_hold + 1;
  endtask

  initial begin
    reset = 1'b1;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    head_at_apple = 1'b0;
    head_hit_body = 1'b0;
    exp_hold = 3;
    #2 reset = 1'b0;
    #1;
    chk("rst_tick", {31'd0, tick}, 0);
    chk("rst_dir", {30'd0, direction}, 0);
    chk("rst_hold", {24'd0, hold_time}, 3);
    chk("rst_eat", {31'd0, eat_apple}, 0);
    chk("rst_over", {31'd0, game_over}, 0);
    chk("rst_run", {31'd0, running}, 0);
    step(); step();
    reset = 1'b1;
    step(); step();

    // 1: start with up, tick period 8
    btn_up = 1'b1; step(); btn_up = 1'b0;
    chk("t1_running", {31'd0, running}, 1);
    chk("t1_tick_low", {31'd0, tick}, 0);
    wait_tick(n);
    chk("t1_first_tick", n, 7);
    chk("t1_dir_before", {30'd0, direction}, 0);
    step();
    chk("t1_dir_up", {30'd0, direction}, 3);
    chk("t1_hold", {24'd0, hold_time}, 3);
    wait_tick(n);
    chk("t1_period", n, 7);
    step();
    chk("t1_no_eat", {31'd0, eat_apple}, 0);

    // 2: right, reject reversal to left, then down
    btn_right = 1'b1; step(); btn_right = 1'b0;
    wait_tick(n); step();
    chk("t2_dir_right", {30'd0, direction}, 0);
    btn_left = 1'b1; step(); btn_left = 1'b0;
    wait_tick(n); step();
    chk("t2_rev_reject", {30'd0, direction}, 0);
    btn_down = 1'b1; step(); btn_down = 1'b0;
    wait_tick(n); step();
    chk("t2_dir_down", {30'd0, direction}, 1);

    // 4: collision and apple in the same tick
    wait_tick(n);
    head_at_apple = 1'b1; head_hit_body = 1'b1;
    step();
    head_at_apple = 1'b0; head_hit_body = 1'b0;
    chk("t4_over", {31'd0, game_over}, 1);
    chk("t4_run", {31'd0, running}, 0);
    chk("t4_hold", {24'd0, hold_time}, 3);
    chk("t4_eat", {31'd0, eat_apple}, 0);
    chk("t4_dir", {30'd0, direction}, 1);
    tcount = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick === 1'b1) tcount++;
    end
    chk("t4_no_ticks", tcount, 0);

    // 5: restart from OVER; the edge is consumed, stays in IDLE
    btn_right = 1'b1; step(); btn_right = 1'b0;
    chk("t5_over_clr", {31'd0, game_over}, 0);
    chk("t5_idle", {31'd0, running}, 0);
    chk("t5_hold", {24'd0, hold_time}, 3);
    chk("t5_dir", {30'd0, direction}, 0);
    tcount = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tick === 1'b1 || running === 1'b1) tcount++;
    end
    chk("t5_idle_hold", tcount, 0);

    // 3: apples, edge in tick cycle, saturation
    exp_per = 8;
    exp_hold = 3;
    btn_down = 1'b1; step(); btn_down = 1'b0;
    chk("t3_running", {31'd0, running}, 1);
    wait_tick(n);
    chk("t3_first_tick", n, 7);
    head_at_apple = 1'b1; btn_right = 1'b1;
    step();
    head_at_apple = 1'b0; btn_right = 1'b0;
    apple_eaten();
    chk("t3_eat", {31'd0, eat_apple}, 1);
    chk("t3_hold", {24'd0, hold_time}, exp_hold);
    chk("t3_dir_down", {30'd0, direction}, 1);
    n = 0;
    while (eat_apple === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk("t3_eat_len", n, exp_per);
    chk("t3_dir_late_edge", {30'd0, direction}, 0);
    wait_tick(n);
    chk("t3_period", n, exp_per - 1);
    head_at_apple = 1'b1;
    step();
    head_at_apple = 1'b0;
    apple_eaten();
    chk("t3_hold_sat", {24'd0, hold_time}, exp_hold);
    chk("t3_eat2", {31'd0, eat_apple}, 1);

    // 5b: asynchronous reset mid-run
    #2 reset = 1'b0;
    #1;
    chk("t5_ar_tick", {31'd0, tick}, 0);
    chk("t5_ar_dir", {30'd0, direction}, 0);
    chk("t5_ar_hold", {24'd0, hold_time}, 3);
    chk("t5_ar_eat", {31'd0, eat_apple}, 0);
    chk("t5_ar_over", {31'd0, game_over}, 0);
    chk("t5_ar_run", {31'd0, running}, 0);
    step();
    reset = 1'b1;
    step();

`ifdef SNAKE_SPEEDUP_EN
    // 6: period shrinks per apple down to 2
    exp_per = 8;
    exp_hold = 3;
    btn_up = 1'b1; step(); btn_up = 1'b0;
    for (int k = 0; k < 9; k++) begin
      wait_tick(n);
      chk("t6_period", n + 1, exp_per);
      head_at_apple = 1'b1;
      step();
      head_at_apple = 1'b0;
      apple_eaten();
    end
    chk("t6_hold", {24'd0, hold_time}, exp_hold);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/snake_step_ctrl.md
Name: snake_step_ctrl

Overview:
- Game-step controller that sits directly upstream of the per-cell light array.
- Turns four player buttons into a registered 2-bit travel direction, generates the game-step tick, and tracks snake length as the per-cell hold time.
- Produces a one-step eat-apple strobe and a game-over flag.
- Every cell in the grid consumes the direction, hold_time and eat_apple outputs, advancing once per tick.

Parameters:
- TICK_DIV, 8: clk cycles per game step; legal range ≥ 2.
- INIT_LEN, 3: hold_time value loaded at reset and on restart (head plus 2 trailing body segments).
- MAX_LEN, 64: hold_time saturation value.
- LEN_W, 8: width of hold_time; must satisfy MAX_LEN < 2^LEN_W.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- btn_up, btn_down, btn_left, btn_right, in, 1 each: synchronised, debounced button levels.
- head_at_apple, in, 1: grid reports the head cell is on the apple cell.
- head_hit_body, in, 1: grid reports the head cell overlaps a body or border cell.
- tick, out, 1: one-clk pulse marking a game step; used as the cell-array step enable.
- direction, out, 2: travel direction; right=00, down=01, left=10, up=11.
- hold_time, out, LEN_W: current snake length, used as the per-cell hold count.
- eat_apple, out, 1: high for exactly one game step after an apple is eaten.
- game_over, out, 1: high while in the OVER state.
- running, out, 1: high while in the RUN state.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE, direction=00 (right), hold_time=INIT_LEN.
  - tick, eat_apple, game_over and running all 0.
  - Tick counter=0; pending-direction register=00 with its valid bit cleared.
  - Button history registers=0.
- Button edges:
  - Each button is edge-detected against a 1-cycle history register; only 0→1 transitions count.
  - When several edges occur in the same cycle, priority is up > down > left > right.
  - A winning edge loads the pending register and sets its valid bit.
  - A later edge before the next tick overwrites the pending value (last press wins).
- FSM states: IDLE, RUN, OVER.
  - IDLE:
    - tick is held at 0 and the counter is held at 0.
    - Any button edge moves to RUN on the next clk.
    - The pending value is kept and applied at the first tick.
  - RUN:
    - running=1.
    - The counter counts 0..TICK_DIV-1 and wraps to 0.
    - tick=1 only during the cycle in which the counter equals TICK_DIV-1, so the first tick comes TICK_DIV cycles after entering RUN.
  - OVER:
    - game_over=1, tick=0, counter held at 0, eat_apple=0.
    - Any button edge moves to IDLE and reloads hold_time=INIT_LEN and direction=00.
    - That edge is consumed; it is not latched as a pending direction.
- Tick cycle in RUN: all of the following take effect registered at the clk edge that ends the tick cycle.
  - Collision: if head_hit_body=1, go to OVER. Direction, hold_time and eat_apple stay unchanged, except that eat_apple is cleared.
  - Apple: otherwise, if head_at_apple=1, set eat_apple=1 and increment hold_time by 1, saturating at MAX_LEN.
  - No apple: otherwise, set eat_apple=0.
  - Direction: if the pending valid bit is set, direction takes the pending value unless pending equals the opposite of the current direction.
    - Opposite is defined as direction XOR 2'b10.
    - A reversal request is discarded.
    - The valid bit is cleared either way.
  - Collision and apple in the same tick: collision wins; hold_time does not increment.
- head_at_apple and head_hit_body are sampled only in tick cycles and ignored in all other cycles.
- eat_apple changes only on tick boundaries, so it stays high for exactly TICK_DIV clk cycles per apple.
- A button edge arriving in the tick cycle itself lands in the pending register after that tick, so it is applied at the following tick.
- Reset asserted mid-game returns every register to its reset value immediately, with no clk needed.

Optional Feature:
- Macro: SNAKE_SPEEDUP_EN.
- With the macro defined:
  - A period register starts at TICK_DIV.
  - Each apple eaten (hold_time increment event) decrements the period by 1, with a floor of 2.
  - The counter wraps at period-1.
  - The period reloads to TICK_DIV on reset and on OVER→IDLE.
- Without the macro, the tick period is fixed at TICK_DIV and no period register exists.

Test Plan:
1. Reset with defaults, then press btn_up → first tick exactly 8 clk after RUN entry, with ticks repeating every 8 clk; direction=11 after that first tick and hold_time=3.
2. In RUN with direction=00, press btn_left → discarded at the next tick, direction remains 00. Then press btn_down → direction=01 at the following tick.
3. head_at_apple=1 during one tick cycle → eat_apple=1 for 8 clk, hold_time 3→4. With MAX_LEN=4, a second apple leaves hold_time at 4.
4. head_at_apple=1 and head_hit_body=1 in the same tick → game_over=1, running=0, hold_time stays 3, eat_apple=0, no further ticks.
5. In OVER, press btn_right → IDLE with hold_time=3 and direction=00. Assert reset low mid-RUN → all outputs at reset values on the same cycle, with no clk edge.
6. With SNAKE_SPEEDUP_EN defined, eat 7 apples → tick period 8,7,…,2, and stays at 2 after the 7th apple.
